// File: rtl/fifo_stream_reader.sv
// Sync-FIFO to valid/ready stream reader with latency-tracked read issue.
// Optional word counter enabled by defining FIFO_STREAM_READER_CNT_EN.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int OW = $clog2(BUF_DEPTH + 1);
  localparam int PW = $clog2(BUF_DEPTH + RD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [OW-1:0]         occ;
  logic [RD_LATENCY-1:0] inflight;
  logic [PW-1:0]         pending;
  logic [OW-1:0]         wr_idx;
  logic                  cap;
  logic                  pop;

  always_comb begin
    pending = PW'(occ);
    for (int i = 0; i < RD_LATENCY; i++) begin
      pending = pending + PW'(inflight[i]);
    end
  end

  assign cap    = inflight[RD_LATENCY-1];
  assign pop    = m_valid & m_ready;
  assign wr_idx = occ - OW'(pop);

  // Issue decision uses only registered state, never m_ready.
  assign fifo_rd_en = !rst && (state == RUN) && !fifo_empty &&
                      (pending < PW'(BUF_DEPTH));

  assign m_valid = (occ != '0);
  assign m_data  = buf_q[0];
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable)
          state_nxt = (pending == '0) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable)
          state_nxt = RUN;
        else if (pending == '0)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= RD_LATENCY'({inflight, fifo_rd_en});
    end
  end

  // Head always sits in entry 0; a pop shifts, a capture lands behind
  // the last live entry (one slot lower when popping in the same cycle).
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      occ <= occ + OW'(cap) - OW'(pop);
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        if (pop) buf_q[i] <= buf_q[i+1];
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (cap && wr_idx == OW'(i)) buf_q[i] <= fifo_rd_data;
      end
    end
  end

`ifdef FIFO_STREAM_READER_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (pop)
      cnt_q <= cnt_q + 1'b1;
  end

  assign word_cnt = cnt_q;
`else
  assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: directed table, corner sequences and
// randomized traffic against a queue-based stream model.
module tb_fifo_stream_reader;

  localparam int LAT = 1;
`ifdef FIFO_STREAM_READER_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic [15:0] word_cnt;

  int checks = 0;
  int failures = 0;

  fifo_stream_reader #(
    .DATA_WIDTH(8),
    .RD_LATENCY(LAT),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .busy(busy),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Sync FIFO model with LAT-cycle read data
  logic [7:0] mem [4096];
  logic [7:0] dl [LAT];
  int wp = 0;
  int rp = 0;

  assign fifo_empty   = (wp == rp);
  assign fifo_rd_data = dl[LAT-1];

  initial begin
    for (int i = 0; i < LAT; i++) dl[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (fifo_rd_en && rp < wp) begin
      dl[0] <= mem[rp[11:0]];
      rp <= rp + 1;
    end
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Stream model: every word read from the FIFO must appear once, in
  // order, unless a reset intervenes.
  logic [7:0]  exp_q [$];
  logic [15:0] cnt_model = '0;
  logic        mon_on = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  hold = '0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (rst) begin
        chk("rd_en_in_rst", fifo_rd_en, 0);
        exp_q.delete();
        cnt_model = '0;
        stall = 1'b0;
      end else begin
        chk("word_cnt", word_cnt, CNT_ON ? cnt_model : 16'd0);
        if (stall) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, hold);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            chk("stream_extra", 1, 0);
          end else begin
            chk("stream_data", m_data, exp_q.pop_front());
          end
          cnt_model = cnt_model + 16'd1;
        end
        if (fifo_rd_en) begin
          chk("rd_when_empty", fifo_empty, 0);
          exp_q.push_back(mem[rp[11:0]]);
        end
        stall = m_valid && !m_ready;
        hold = m_data;
      end
    end
  end

  task automatic tick(input logic r, input logic e, input logic rd);
    @(posedge clk);
    #1;
    rst = r;
    enable = e;
    m_ready = rd;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wp[11:0]] = v;
    wp++;
  endtask

  typedef struct {
    logic       r;
    logic       en;
    logic       rdy;
    logic       psh;
    logic [7:0] val;
    logic       e_rd;
    logic       e_mv;
    logic       e_busy;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl [11];

  int first_rd, first_mv, last_mv, nmv, nrd;
  logic [7:0] got [$];
  logic seen_idle;

  initial begin
    //         r  en rdy psh val    rd mv busy data
    tbl[0]  = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00};
    tbl[1]  = '{0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00};
    tbl[2]  = '{0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00};
    tbl[3]  = '{0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00};
    tbl[4]  = '{0, 1, 0, 1, 8'h5A, 1, 0, 1, 8'h00};
    tbl[5]  = '{0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h00};
    tbl[6]  = '{0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h5A};
    tbl[7]  = '{0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h5A};
    tbl[8]  = '{0, 0, 1, 0, 8'h00, 0, 1, 1, 8'h5A};
    tbl[9]  = '{0, 0, 1, 0, 8'h00, 0, 0, 1, 8'h00};
    tbl[10] = '{0, 0, 1, 0, 8'h00, 0, 0, 0, 8'h00};

    rst = 1'b1;
    enable = 1'b0;
    m_ready = 1'b0;
    tick(1, 0, 0);
    tick(1, 0, 0);
    @(negedge clk);
    chk("reset_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", m_data, 0);
    chk("reset_cnt", word_cnt, 0);
    mon_on = 1'b1;

    // Directed table: empty-FIFO wait, single word, drain to idle
    for (int i = 0; i < 11; i++) begin
      tick(tbl[i].r, tbl[i].en, tbl[i].rdy);
      if (tbl[i].psh) push(tbl[i].val);
      @(negedge clk);
      chk($sformatf("tbl%0d_rd_en", i), fifo_rd_en, tbl[i].e_rd);
      chk($sformatf("tbl%0d_valid", i), m_valid, tbl[i].e_mv);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_mv)
        chk($sformatf("tbl%0d_data", i), m_data, tbl[i].e_data);
    end

    // Full-rate stream of 1..8
    for (int v = 1; v <= 8; v++) push(8'(v));
    first_rd = -1;
    first_mv = -1;
    last_mv = -1;
    nmv = 0;
    got.delete();
    for (int c = 0; c < 30; c++) begin
      tick(0, 1, 1);
      @(negedge clk);
      if (fifo_rd_en && first_rd < 0) first_rd = c;
      if (m_valid) begin
        if (first_mv < 0) first_mv = c;
        last_mv = c;
        nmv++;
        got.push_back(m_data);
      end
    end
    chk("rate_latency", first_mv - first_rd, 2);
    chk("rate_count", nmv, 8);
    chk("rate_contig", last_mv - first_mv + 1, 8);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("rate_data%0d", i), got[i], i + 1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    @(negedge clk);
    chk("rate_word_cnt", word_cnt, CNT_ON ? 9 : 0);
    chk("rate_idle", busy, 0);

    // Back-pressure: only BUF_DEPTH reads while the sink stalls
    for (int v = 1; v <= 8; v++) push(8'(v));
    nrd = 0;
    for (int c = 0; c < 12; c++) begin
      tick(0, 1, 0);
      @(negedge clk);
      if (fifo_rd_en) nrd++;
    end
    chk("bp_reads", nrd, LAT + 2);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 1);
    got.delete();
    for (int c = 0; c < 20; c++) begin
      tick(0, 1, 1);
      @(negedge clk);
      if (m_valid) got.push_back(m_data);
    end
    chk("bp_count", got.size(), 8);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp_data%0d", i), got[i], i + 1);
    tick(0, 0, 1);
    tick(0, 0, 1);

    // Drop enable mid-stream: drain without new reads
    for (int v = 0; v < 20; v++) push(8'(8'h20 + v));
    for (int c = 0; c < 8; c++) tick(0, 1, 1);
    tick(0, 0, 1);
    nrd = 0;
    seen_idle = 1'b0;
    for (int c = 0; c < 20 && !seen_idle; c++) begin
      tick(0, 0, 1);
      @(negedge clk);
      if (c == 0) chk("drain_busy", busy, 1);
      if (fifo_rd_en) nrd++;
      if (!busy) seen_idle = 1'b1;
    end
    chk("drain_reads", nrd, 0);
    chk("drain_idle", seen_idle, 1);
    tick(0, 0, 1);
    chk("drain_delivered", exp_q.size(), 0);

    // Reset with two words buffered and one in flight
    nrd = 0;
    for (int c = 0; c < 10 && nrd < 3; c++) begin
      tick(0, 1, 0);
      @(negedge clk);
      if (fifo_rd_en) nrd++;
    end
    chk("rst_setup_reads", nrd, 3);
    tick(1, 1, 0);
    @(negedge clk);
    chk("rst_rd_en", fifo_rd_en, 0);
    tick(0, 0, 1);
    @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_rd_en_after", fifo_rd_en, 0);
    nmv = 0;
    for (int c = 0; c < 6; c++) begin
      tick(0, 0, 1);
      @(negedge clk);
      if (m_valid) nmv++;
    end
    chk("rst_no_stale", nmv, 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1 && wp < 4000) push(8'($urandom));
    end

    seen_idle = 1'b0;
    for (int c = 0; c < 200 && !seen_idle; c++) begin
      tick(0, 1, 1);
      if (wp == rp && exp_q.size() == 0 && !m_valid) seen_idle = 1'b1;
    end
    chk("final_flush", seen_idle, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, FIFO data and stream width in bits.
REQ-002 SHALL have parameter RD_LATENCY, default 1, cycles from fifo_rd_en high to valid fifo_rd_data; legal values 1 or 2.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of word_cnt.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  allows new FIFO reads while high.
REQ-007 SHALL have port fifo_empty  input  1  sync FIFO empty flag.
REQ-008 SHALL have port fifo_rd_en  output  1  read strobe to the sync FIFO.
REQ-009 SHALL have port fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid RD_LATENCY cycles after fifo_rd_en.
REQ-010 SHALL have port m_valid  output  1  stream data valid.
REQ-011 SHALL have port m_ready  input  1  stream sink ready.
REQ-012 SHALL have port m_data  output  DATA_WIDTH  stream data.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port word_cnt  output  CNT_WIDTH  count of words accepted on the stream.

Function
REQ-015 SHALL hold an internal output buffer of BUF_DEPTH = RD_LATENCY+2 entries, FIFO ordered.
REQ-016 SHALL track in-flight reads with a RD_LATENCY-deep valid shift register; pending = buffer occupancy + in-flight count.
REQ-017 SHALL drive fifo_rd_en = (state==RUN) & !fifo_empty & (pending < BUF_DEPTH), using registered pending only; no path from m_ready to fifo_rd_en.
REQ-018 SHALL write fifo_rd_data into the buffer tail in the cycle the in-flight valid bit exits the shift register.
REQ-019 SHALL drive m_valid = (occupancy != 0) and m_data = buffer head, both from registers.
REQ-020 SHALL pop the head on m_valid & m_ready; simultaneous pop and capture leaves occupancy unchanged.
REQ-021 SHALL hold m_data stable while m_valid & !m_ready.
REQ-022 SHALL sustain one word per cycle with m_ready held high and FIFO non-empty.
REQ-023 SHALL never issue fifo_rd_en while fifo_empty is high; buffer overflow SHALL be impossible by construction.
REQ-024 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on enable; RUN->IDLE on !enable & pending==0; RUN->DRAIN on !enable & pending!=0; DRAIN->RUN on enable; DRAIN->IDLE when pending==0.
REQ-025 SHALL deliver all in-flight and buffered words in DRAIN with no new reads.
REQ-026 SHALL increment word_cnt on each m_valid & m_ready, wrapping modulo 2^CNT_WIDTH.

Reset
REQ-027 SHALL, on rst high at a clock edge, set state IDLE, clear buffer, shift register and word_cnt; m_valid=0, busy=0, m_data=0.
REQ-028 SHALL force fifo_rd_en low during any cycle rst is high.
REQ-029 SHALL discard in-flight and buffered words on reset mid-operation; those words are lost from the FIFO.

Configuration
REQ-030 SHALL implement word_cnt only when macro FIFO_STREAM_READER_CNT_EN is defined.
REQ-031 SHALL, without FIFO_STREAM_READER_CNT_EN, tie word_cnt to zero and include no counter register; all other behaviour unchanged.

Verification
REQ-032 Sync FIFO preloaded with 1..8, enable=1, m_ready=1, RD_LATENCY=1 -> m_data 1..8 on 8 consecutive m_valid cycles, first m_valid 2 cycles after first fifo_rd_en, word_cnt=8.
REQ-033 FIFO holds 1..8, m_ready=0 -> exactly BUF_DEPTH (3) fifo_rd_en pulses, m_valid high with m_data=1 held; m_ready=1 -> remaining 2..8 in order, no loss or duplicate.
REQ-034 Empty FIFO, enable=1 -> fifo_rd_en stays 0, m_valid 0, busy 1; write one word 0x5A -> single read, m_data=0x5A.
REQ-035 Streaming at full rate, enable dropped -> state DRAIN, no further fifo_rd_en, in-flight words delivered, then IDLE and busy=0.
REQ-036 rst asserted with 2 words buffered and 1 in flight -> next cycle m_valid=0, busy=0, word_cnt=0, fifo_rd_en=0; no stale word emitted afterwards.
REQ-037 Build without FIFO_STREAM_READER_CNT_EN, rerun REQ-032 -> identical stream, word_cnt constant 0.
